mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Executes the load/store operation encoded by a mem_ctrl_t code from the decode stage.
//  Takes the code, effective address and store data from the core, and runs one bus
//  transaction on a valid/ready request + valid response port. Store data is steered to
//  byte lanes; load data is extracted, extended and returned. Sits between the execute
//  stage and the data-memory bus.
// PARAMETERS
//  ADDR_W   32  bus address width; core address is word_t, upper bits truncated
//  TIMEOUT  255 cycles waiting for bus_rsp_valid before err is raised; 0 = never time out
// PORTS
//  clk            in   1   single clock, rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  start          in   1   core requests execution of mem_ctrl; sampled only in IDLE
//  mem_ctrl       in   mem_ctrl_t  operation code (NONE/READ_*/STORE_*)
//  load_unsigned  in   1   zero-extend byte/half loads (funct3[2] from decode)
//  addr           in   32  effective byte address
//  wdata          in   32  store source register value
//  busy           out  1   unit not in IDLE
//  done           out  1   1-cycle pulse: operation finished (with or without err)
//  err            out  1   valid with done: misaligned access or bus timeout
//  rdata          out  32  load result, valid with done; held until next done
//  bus_req_valid  out  1   bus request valid
//  bus_req_ready  in   1   bus accepts request
//  bus_addr       out  ADDR_W word-aligned address (addr[1:0] forced to 0)
//  bus_we         out  1   1 = write
//  bus_wstrb      out  4   byte-lane write enables
//  bus_wdata      out  32  lane-steered write data
//  bus_rsp_valid  in   1   response valid (reads: data; writes: acknowledge)
//  bus_rdata      in   32  read data word
// BEHAVIOUR
//  - Reset: FSM=IDLE, busy=0, done=0, err=0, rdata=0, bus_req_valid=0, bus_we=0,
//    bus_wstrb=0, bus_addr=0, bus_wdata=0, timeout counter=0. Reset mid-transaction
//    aborts it; a late bus_rsp_valid after reset is ignored in IDLE.
//  - States: IDLE -> REQ -> RSP -> DONE -> IDLE.
//  - IDLE: start && mem_ctrl==NONE -> DONE (no bus access, rdata unchanged). start with
//    misaligned access (half: addr[0]!=0; word: addr[1:0]!=0) -> DONE with err=1, no bus
//    access. Otherwise register addr/ctrl/data, go REQ.
//  - REQ: bus_req_valid=1; address/we/wstrb/wdata stable while valid && !ready.
//    Handshake on valid&&ready -> RSP. Never drop valid before ready.
//  - RSP: wait bus_rsp_valid; count cycles; counter==TIMEOUT (TIMEOUT!=0) -> DONE err=1.
//    bus_rsp_valid in the handshake cycle is not accepted (response earliest next cycle).
//  - DONE: done=1 for exactly one cycle, busy=0 from next cycle; start in DONE ignored.
//  - Minimum latency start -> done: 3 cycles with zero-wait bus; NONE/misaligned: 1 cycle.
//  - Store lanes: byte: wstrb=1<<addr[1:0], wdata={4{wdata[7:0]}}; half:
//    wstrb=addr[1]?4'b1100:4'b0011, wdata={2{wdata[15:0]}}; word: wstrb=4'hF.
//  - Load: byte=bus_rdata[8*addr[1:0]+:8], half=bus_rdata[16*addr[1]+:16], word=all;
//    sign-extend unless load_unsigned; load_unsigned ignored for words.
//  - Reads use bus_we=0, wstrb=4'h0. rdata updates only on successful load completion.
// STRUCTURE
//  - Shared package (types.sv): mem_ctrl_t and MEM_CTRL_* codes, word_t, new
//    mem_fsm_t enum {MEM_IDLE, MEM_REQ, MEM_RSP, MEM_DONE}.
//  - One sub-module: mem_lane_align (combinational: store lane steering + load
//    extract/extend), reused by the future instruction-fetch path for halfword fetch.
//  - FSM, timeout counter and request registers stay in this module.
// TESTING
//  - STORE_BYTE addr=0x1003 wdata=0x000000A5, ready=1 -> wstrb=4'b1000, bus_addr=0x1000,
//    wdata=0xA5A5A5A5, done 3 cycles after start, err=0.
//  - READ_HALF addr=0x2002 bus_rdata=0x8001_1234, signed -> rdata=0xFFFF8001;
//    load_unsigned=1 -> 0x00008001.
//  - READ_WORD addr=0x3001 -> done next cycle, err=1, no bus_req_valid ever asserted.
//  - bus_req_ready low 5 cycles -> valid, addr, wstrb held stable; done after ready+rsp.
//  - TIMEOUT=4, no bus_rsp_valid -> done with err=1 exactly 4 cycles after handshake.
//  - rst_n low in RSP, then rsp pulse -> outputs at reset values, no done, FSM in IDLE.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared load/store types: operation codes, data word, unit FSM states and
// decode helpers used by the memory access unit and its lane aligner.
package mem_access_unit_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [2:0] {
    MEM_CTRL_NONE       = 3'd0,
    MEM_CTRL_READ_BYTE  = 3'd1,
    MEM_CTRL_READ_HALF  = 3'd2,
    MEM_CTRL_READ_WORD  = 3'd3,
    MEM_CTRL_STORE_BYTE = 3'd4,
    MEM_CTRL_STORE_HALF = 3'd5,
    MEM_CTRL_STORE_WORD = 3'd6
  } mem_ctrl_t;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RSP  = 2'd2,
    MEM_DONE = 2'd3
  } mem_fsm_t;

  function automatic logic ctrl_is_store(input mem_ctrl_t c);
    logic r;
    case (c)
      MEM_CTRL_STORE_BYTE, MEM_CTRL_STORE_HALF, MEM_CTRL_STORE_WORD: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic ctrl_is_load(input mem_ctrl_t c);
    logic r;
    case (c)
      MEM_CTRL_READ_BYTE, MEM_CTRL_READ_HALF, MEM_CTRL_READ_WORD: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Halfwords need addr[0]==0, words need addr[1:0]==0; bytes are always aligned.
  function automatic logic ctrl_misaligned(input mem_ctrl_t c, input logic [1:0] a);
    logic r;
    case (c)
      MEM_CTRL_READ_HALF, MEM_CTRL_STORE_HALF: r = a[0];
      MEM_CTRL_READ_WORD, MEM_CTRL_STORE_WORD: r = (a != 2'b00);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// Combinational byte-lane steering for stores and extract/extend for loads.
// Kept stand-alone so the fetch path can reuse it for halfword fetches.
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  mem_ctrl_t   ctrl_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        load_unsigned_i,
  input  word_t       store_data_i,
  input  word_t       load_word_i,
  output logic [3:0]  wstrb_o,
  output word_t       wdata_o,
  output word_t       rdata_o
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  assign byte_s = load_word_i[{addr_lo_i, 3'b000} +: 8];
  assign half_s = load_word_i[{addr_lo_i[1], 4'b0000} +: 16];

  // Store side: replicate the source so every enabled lane sees the right bytes.
  always_comb begin
    wstrb_o = 4'h0;
    wdata_o = 32'h0000_0000;
    case (ctrl_i)
      MEM_CTRL_STORE_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      MEM_CTRL_STORE_HALF: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{store_data_i[15:0]}};
      end
      MEM_CTRL_STORE_WORD: begin
        wstrb_o = 4'hF;
        wdata_o = store_data_i;
      end
      default: begin
        wstrb_o = 4'h0;
        wdata_o = 32'h0000_0000;
      end
    endcase
  end

  // Load side: pick the addressed lane and extend; words ignore load_unsigned.
  always_comb begin
    rdata_o = 32'h0000_0000;
    case (ctrl_i)
      MEM_CTRL_READ_BYTE: begin
        if (load_unsigned_i) rdata_o = {24'h00_0000, byte_s};
        else                 rdata_o = {{24{byte_s[7]}}, byte_s};
      end
      MEM_CTRL_READ_HALF: begin
        if (load_unsigned_i) rdata_o = {16'h0000, half_s};
        else                 rdata_o = {{16{half_s[15]}}, half_s};
      end
      MEM_CTRL_READ_WORD: rdata_o = load_word_i;
      default:            rdata_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store execution unit: runs one valid/ready bus transaction per start,
// with alignment checking, response timeout and registered result outputs.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  mem_ctrl_t         mem_ctrl,
  input  logic              load_unsigned,
  input  word_t             addr,
  input  word_t             wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output word_t             rdata,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic [3:0]        bus_wstrb,
  output word_t             bus_wdata,
  input  logic              bus_rsp_valid,
  input  word_t             bus_rdata
);

  localparam int CNT_W      = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  mem_fsm_t          state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc_s;
  mem_ctrl_t         ctrl_q;
  logic [1:0]        addr_lo_q;
  logic              uns_q;
  logic              busy_q, done_q, err_q, req_valid_q, we_q;
  word_t             rdata_q, wdata_q;
  logic [ADDR_W-1:0] addr_q;
  logic [3:0]        wstrb_q;
  logic              err_d, launch_s, load_ok_s;

  mem_ctrl_t         align_ctrl_s;
  logic [1:0]        align_addr_s;
  logic [3:0]        align_wstrb_s;
  word_t             align_wdata_s, align_rdata_s;

  // In IDLE the aligner steers the incoming store; afterwards it decodes the captured load.
  assign align_ctrl_s = (state_q == MEM_IDLE) ? mem_ctrl   : ctrl_q;
  assign align_addr_s = (state_q == MEM_IDLE) ? addr[1:0]  : addr_lo_q;
  assign cnt_inc_s    = cnt_q + CNT_W'(1);

  mem_lane_align u_align (
    .ctrl_i          (align_ctrl_s),
    .addr_lo_i       (align_addr_s),
    .load_unsigned_i (uns_q),
    .store_data_i    (wdata),
    .load_word_i     (bus_rdata),
    .wstrb_o         (align_wstrb_s),
    .wdata_o         (align_wdata_s),
    .rdata_o         (align_rdata_s)
  );

  // Next-state, error and capture decisions for the transaction FSM.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = 1'b0;
    launch_s  = 1'b0;
    load_ok_s = 1'b0;
    case (state_q)
      MEM_IDLE: begin
        if (!start) begin
          state_d = MEM_IDLE;
        end else if (mem_ctrl == MEM_CTRL_NONE) begin
          state_d = MEM_DONE;
        end else if (ctrl_misaligned(mem_ctrl, addr[1:0])) begin
          state_d = MEM_DONE;
          err_d   = 1'b1;
        end else begin
          state_d  = MEM_REQ;
          launch_s = 1'b1;
        end
      end
      MEM_REQ: begin
        if (bus_req_ready) begin
          state_d = MEM_RSP;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_RSP: begin
        if (bus_rsp_valid) begin
          state_d   = MEM_DONE;
          load_ok_s = ctrl_is_load(ctrl_q);
        end else if (TIMEOUT_EN && (cnt_inc_s == CNT_W'(TIMEOUT))) begin
          // TIMEOUT full cycles spent in RSP without a response.
          state_d = MEM_DONE;
          err_d   = 1'b1;
        end else begin
          cnt_d = TIMEOUT_EN ? cnt_inc_s : cnt_q;
        end
      end
      MEM_DONE: state_d = MEM_IDLE;
      default:  state_d = MEM_IDLE;
    endcase
  end

  // State, counter, request registers and registered status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= MEM_IDLE;
      cnt_q       <= {CNT_W{1'b0}};
      ctrl_q      <= MEM_CTRL_NONE;
      addr_lo_q   <= 2'b00;
      uns_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      req_valid_q <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      we_q        <= 1'b0;
      wstrb_q     <= 4'h0;
      wdata_q     <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != MEM_IDLE);
      done_q      <= (state_d == MEM_DONE);
      err_q       <= err_d;
      req_valid_q <= (state_d == MEM_REQ);
      if (launch_s) begin
        ctrl_q    <= mem_ctrl;
        addr_lo_q <= addr[1:0];
        uns_q     <= load_unsigned;
        addr_q    <= ADDR_W'({addr[31:2], 2'b00});
        we_q      <= ctrl_is_store(mem_ctrl);
        wstrb_q   <= align_wstrb_s;
        wdata_q   <= align_wdata_s;
      end
      if (load_ok_s) begin
        rdata_q <= align_rdata_s;
      end
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign rdata         = rdata_q;
  assign bus_req_valid = req_valid_q;
  assign bus_addr      = addr_q;
  assign bus_we        = we_q;
  assign bus_wstrb     = wstrb_q;
  assign bus_wdata     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit (TIMEOUT=4 instance).
module tb_mem_access_unit;
  import mem_access_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  mem_ctrl_t   mem_ctrl = MEM_CTRL_NONE;
  logic        load_unsigned = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        busy, done, err, bus_req_valid, bus_we;
  logic [31:0] rdata, bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_req_ready = 1'b1;
  logic        bus_rsp_valid = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  int n_checks = 0;
  int n_fail = 0;

  int          lat, valid_cycles;
  logic        saw_done, saw_valid, unstable;
  logic [31:0] cap_addr, cap_wdata;
  logic [3:0]  cap_wstrb;
  logic        cap_we;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_ctrl(mem_ctrl),
    .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .err(err), .rdata(rdata),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready),
    .bus_addr(bus_addr), .bus_we(bus_we), .bus_wstrb(bus_wstrb),
    .bus_wdata(bus_wdata), .bus_rsp_valid(bus_rsp_valid), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called at a negedge: present an operation, sampled at the next posedge.
  task automatic issue(input mem_ctrl_t c, input logic [31:0] a, input logic [31:0] d, input logic u);
    mem_ctrl = c; addr = a; wdata = d; load_unsigned = u; start = 1'b1;
  endtask

  // Acts as the bus: answers one cycle after each handshake when give_rsp is set,
  // records the request seen and whether it stayed stable, and counts cycles to done.
  task automatic run_op(input int max_cyc, input int ready_delay, input logic give_rsp, input logic [31:0] rd);
    logic hs;
    hs = 1'b0; lat = 0; saw_done = 1'b0; saw_valid = 1'b0; unstable = 1'b0; valid_cycles = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      bus_rsp_valid = hs && give_rsp;
      bus_rdata = rd;
      bus_req_ready = (i > ready_delay);
      if (bus_req_valid) begin
        if (!saw_valid) begin
          cap_addr = bus_addr; cap_wdata = bus_wdata; cap_wstrb = bus_wstrb; cap_we = bus_we;
        end else if (bus_addr !== cap_addr || bus_wdata !== cap_wdata || bus_wstrb !== cap_wstrb || bus_we !== cap_we) begin
          unstable = 1'b1;
        end
        saw_valid = 1'b1;
        valid_cycles++;
      end
      hs = bus_req_valid && bus_req_ready;
      if (done) begin
        saw_done = 1'b1; lat = i;
        break;
      end
    end
    bus_rsp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({busy, done, err, bus_req_valid, bus_we, bus_wstrb} !== 9'h000) begin n_fail++; $display("FAIL reset_ctl: got %b expected 000000000", {busy, done, err, bus_req_valid, bus_we, bus_wstrb}); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata); end
    n_checks++; if (bus_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 00000000", bus_addr); end
    n_checks++; if (bus_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 00000000", bus_wdata); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_store_byte;
    issue(MEM_CTRL_STORE_BYTE, 32'h0000_1003, 32'h0000_00A5, 1'b0);
    run_op(20, 0, 1'b1, 32'h5555_5555);
    n_checks++; if (!saw_done || lat !== 3) begin n_fail++; $display("FAIL sb_latency: got %0d (done=%0d) expected 3", lat, saw_done); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL sb_err: got %b expected 0", err); end
    n_checks++; if (cap_wstrb !== 4'b1000) begin n_fail++; $display("FAIL sb_wstrb: got %b expected 1000", cap_wstrb); end
    n_checks++; if (cap_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL sb_addr: got %h expected 00001000", cap_addr); end
    n_checks++; if (cap_wdata !== 32'hA5A5_A5A5 || cap_we !== 1'b1) begin n_fail++; $display("FAIL sb_wdata: got %h we=%b expected a5a5a5a5 we=1", cap_wdata, cap_we); end
    n_checks++; if (rdata !== 32'h0) begin n_fail++; $display("FAIL sb_rdata_kept: got %h expected 00000000", rdata); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL sb_done_pulse: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  task automatic test_store_lanes;
    issue(MEM_CTRL_STORE_HALF, 32'h0000_0012, 32'h0000_BEEF, 1'b0);
    run_op(20, 0, 1'b1, 32'h0);
    n_checks++; if (cap_wstrb !== 4'b1100 || cap_wdata !== 32'hBEEF_BEEF || cap_addr !== 32'h10) begin n_fail++; $display("FAIL sh_lanes: got %b %h %h expected 1100 beefbeef 00000010", cap_wstrb, cap_wdata, cap_addr); end
    @(negedge clk);
    issue(MEM_CTRL_STORE_WORD, 32'h0000_0020, 32'h1234_5678, 1'b0);
    run_op(20, 0, 1'b1, 32'h0);
    n_checks++; if (cap_wstrb !== 4'hF || cap_wdata !== 32'h1234_5678 || cap_addr !== 32'h20) begin n_fail++; $display("FAIL sw_lanes: got %b %h %h expected 1111 12345678 00000020", cap_wstrb, cap_wdata, cap_addr); end
    @(negedge clk);
  endtask

  task automatic test_read_half;
    issue(MEM_CTRL_READ_HALF, 32'h0000_2002, 32'h0, 1'b0);
    run_op(20, 0, 1'b1, 32'h8001_1234);
    n_checks++; if (rdata !== 32'hFFFF_8001 || lat !== 3 || err !== 1'b0) begin n_fail++; $display("FAIL lh_signed: got %h lat=%0d err=%b expected ffff8001 3 0", rdata, lat, err); end
    n_checks++; if (cap_we !== 1'b0 || cap_wstrb !== 4'h0 || cap_addr !== 32'h2000) begin n_fail++; $display("FAIL lh_req: got we=%b wstrb=%b addr=%h expected 0 0000 00002000", cap_we, cap_wstrb, cap_addr); end
    @(negedge clk);
    issue(MEM_CTRL_READ_HALF, 32'h0000_2002, 32'h0, 1'b1);
    run_op(20, 0, 1'b1, 32'h8001_1234);
    n_checks++; if (rdata !== 32'h0000_8001) begin n_fail++; $display("FAIL lh_unsigned: got %h expected 00008001", rdata); end
    @(negedge clk);
  endtask

  task automatic test_read_byte_word;
    issue(MEM_CTRL_READ_BYTE, 32'h0000_0001, 32'h0, 1'b0);
    run_op(20, 0, 1'b1, 32'h1122_8344);
    n_checks++; if (rdata !== 32'hFFFF_FF83) begin n_fail++; $display("FAIL lb_signed: got %h expected ffffff83", rdata); end
    @(negedge clk);
    issue(MEM_CTRL_READ_BYTE, 32'h0000_0007, 32'h0, 1'b1);
    run_op(20, 0, 1'b1, 32'hAB00_0000);
    n_checks++; if (rdata !== 32'h0000_00AB) begin n_fail++; $display("FAIL lbu_lane3: got %h expected 000000ab", rdata); end
    @(negedge clk);
    issue(MEM_CTRL_READ_WORD, 32'h0000_0004, 32'h0, 1'b1);
    run_op(20, 0, 1'b1, 32'hDEAD_BEEF);
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw: got %h expected deadbeef", rdata); end
    @(negedge clk);
  endtask

  task automatic test_misaligned;
    issue(MEM_CTRL_READ_WORD, 32'h0000_3001, 32'h0, 1'b0);
    run_op(10, 0, 1'b1, 32'h0BAD_0BAD);
    n_checks++; if (lat !== 1 || err !== 1'b1 || saw_valid !== 1'b0) begin n_fail++; $display("FAIL lw_misaligned: got lat=%0d err=%b req=%b expected 1 1 0", lat, err, saw_valid); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_misaligned_rdata: got %h expected deadbeef", rdata); end
    @(negedge clk);
    issue(MEM_CTRL_STORE_HALF, 32'h0000_0005, 32'h1, 1'b0);
    run_op(10, 0, 1'b1, 32'h0);
    n_checks++; if (lat !== 1 || err !== 1'b1 || saw_valid !== 1'b0) begin n_fail++; $display("FAIL sh_misaligned: got lat=%0d err=%b req=%b expected 1 1 0", lat, err, saw_valid); end
    @(negedge clk);
  endtask

  task automatic test_none;
    issue(MEM_CTRL_NONE, 32'h0000_0003, 32'h0, 1'b0);
    run_op(10, 0, 1'b1, 32'h0);
    n_checks++; if (lat !== 1 || err !== 1'b0 || saw_valid !== 1'b0 || rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL none_op: got lat=%0d err=%b req=%b rdata=%h expected 1 0 0 deadbeef", lat, err, saw_valid, rdata); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    issue(MEM_CTRL_NONE, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    n_checks++; if (done !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got done=%b busy=%b expected 1 1", done, busy); end
    mem_ctrl = MEM_CTRL_STORE_WORD;
    @(negedge clk);
    start = 1'b0;
    n_checks++; if (done !== 1'b0 || busy !== 1'b0 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_start_in_done: got done=%b busy=%b valid=%b expected 0 0 0", done, busy, bus_req_valid); end
    @(negedge clk);
  endtask

  task automatic test_ready_stall;
    issue(MEM_CTRL_STORE_WORD, 32'h0000_0044, 32'hCAFE_F00D, 1'b0);
    run_op(30, 5, 1'b1, 32'h0);
    n_checks++; if (valid_cycles !== 6 || unstable !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got valid_cycles=%0d unstable=%b expected 6 0", valid_cycles, unstable); end
    n_checks++; if (cap_addr !== 32'h44 || cap_wstrb !== 4'hF || cap_wdata !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL stall_req: got %h %b %h expected 00000044 1111 cafef00d", cap_addr, cap_wstrb, cap_wdata); end
    n_checks++; if (lat !== 8 || err !== 1'b0) begin n_fail++; $display("FAIL stall_latency: got lat=%0d err=%b expected 8 0", lat, err); end
    @(negedge clk);
  endtask

  // Handshake closes cycle 1; four RSP cycles (2..5) without response, done in cycle 6.
  task automatic test_timeout;
    issue(MEM_CTRL_READ_WORD, 32'h0000_0080, 32'h0, 1'b0);
    run_op(20, 0, 1'b0, 32'h1111_1111);
    n_checks++; if (!saw_done || lat !== 6 || err !== 1'b1) begin n_fail++; $display("FAIL timeout: got lat=%0d done=%b err=%b expected 6 1 1", lat, saw_done, err); end
    n_checks++; if (rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL timeout_rdata: got %h expected deadbeef", rdata); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL timeout_after: got done=%b err=%b busy=%b expected 0 0 0", done, err, busy); end
  endtask

  task automatic test_reset_mid;
    bus_req_ready = 1'b1;
    issue(MEM_CTRL_READ_WORD, 32'h0000_0100, 32'h0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1 || bus_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_in_rsp: got busy=%b valid=%b expected 1 0", busy, bus_req_valid); end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus_rsp_valid = 1'b1;
    bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_rsp_valid = 1'b0;
    n_checks++; if ({busy, done, err, bus_req_valid} !== 4'b0000 || rdata !== 32'h0 || bus_addr !== 32'h0) begin n_fail++; $display("FAIL mid_reset: got ctl=%b rdata=%h addr=%h expected 0000 00000000 00000000", {busy, done, err, bus_req_valid}, rdata, bus_addr); end
    @(negedge clk);
    n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_idle: got done=%b busy=%b expected 0 0", done, busy); end
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_lanes();
    test_read_half();
    test_read_byte_word();
    test_misaligned();
    test_none();
    test_back_to_back();
    test_ready_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
